// File: rtl/joypad_pkg.sv
// Shared definitions for the joypad poll scheduler: FSM states, button bit
// positions and default timing parameters.
package joypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_PULSE  = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int TICK_CYCLES_DEF = 198;
    localparam int POLL_TICKS_DEF  = 2750;

endpackage

// File: rtl/joypad_tick_gen.sv
// Free-running protocol tick prescaler plus poll-period counter; poll_start
// marks the tick on which the poll counter wraps.
module joypad_tick_gen
    import joypad_pkg::*;
#(
    parameter int TICK_CYCLES = TICK_CYCLES_DEF,
    parameter int POLL_TICKS  = POLL_TICKS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic poll_start
);

    localparam int TW = $clog2(TICK_CYCLES);
    localparam int PW = $clog2(POLL_TICKS);

    logic [TW-1:0] tick_cnt;
    logic [PW-1:0] poll_cnt;
    logic          tick_last;
    logic          poll_last;

    assign tick_last  = (tick_cnt == TW'(TICK_CYCLES - 1));
    assign poll_last  = (poll_cnt == PW'(POLL_TICKS - 1));
    assign tick       = tick_last;
    assign poll_start = tick_last && poll_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            poll_cnt <= '0;
        end else begin
            if (tick_last) begin
                tick_cnt <= '0;
                poll_cnt <= poll_last ? '0 : poll_cnt + PW'(1);
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
        end
    end

endmodule

// File: rtl/joypad_scheduler.sv
// Joypad poll scheduler: latches and shifts a serial controller once per poll
// period, debounces over two frames and presents the P1x joypad register.
//
// state     | meaning
// ST_IDLE   | waiting for a poll wrap with I_POLL_EN set
// ST_LATCH  | O_LATCH high for two ticks, bit index cleared
// ST_SAMPLE | one tick settle; data bit captured on the closing tick
// ST_PULSE  | O_PULSE high for one tick, advances to next bit
// ST_COMMIT | one clock: debounce compare and button update
module joypad_scheduler
    import joypad_pkg::*;
#(
    parameter int TICK_CYCLES = TICK_CYCLES_DEF,
    parameter int POLL_TICKS  = POLL_TICKS_DEF
) (
    input  logic       I_CLK_33MHZ,
    input  logic       I_RESET_N,
    input  logic       I_DATA,
    input  logic       I_POLL_EN,
    input  logic       I_SEL_DIR_N,
    input  logic       I_SEL_BTN_N,
    output logic       O_LATCH,
    output logic       O_PULSE,
    output logic [7:0] O_BUTTONS,
    output logic [3:0] O_JOYP_LO,
    output logic       O_INT,
    output logic       O_BUSY
);

    state_t     state;
    logic       tick;
    logic       poll_start;
    logic [1:0] sync;
    logic       lat_cnt;
    logic [2:0] bit_idx;
    logic [7:0] raw;
    logic [7:0] prev_raw;
    logic [3:0] joyp_prev;
    logic [3:0] dir_n;
    logic [3:0] btn_n;

    joypad_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES),
        .POLL_TICKS (POLL_TICKS)
    ) u_tick_gen (
        .clk       (I_CLK_33MHZ),
        .rst_n     (I_RESET_N),
        .tick      (tick),
        .poll_start(poll_start)
    );

    always_ff @(posedge I_CLK_33MHZ or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state     <= ST_IDLE;
            sync      <= 2'b11;
            lat_cnt   <= 1'b0;
            bit_idx   <= 3'd0;
            raw       <= 8'h00;
            prev_raw  <= 8'h00;
            O_LATCH   <= 1'b0;
            O_PULSE   <= 1'b0;
            O_BUTTONS <= 8'h00;
            O_BUSY    <= 1'b0;
        end else begin
            sync <= {sync[0], I_DATA};
            case (state)
                ST_IDLE: begin
                    if (poll_start && I_POLL_EN) begin
                        state   <= ST_LATCH;
                        O_LATCH <= 1'b1;
                        O_BUSY  <= 1'b1;
                        bit_idx <= 3'd0;
                        lat_cnt <= 1'b0;
                    end
                end
                ST_LATCH: begin
                    if (tick) begin
                        if (lat_cnt) begin
                            state   <= ST_SAMPLE;
                            O_LATCH <= 1'b0;
                        end else begin
                            lat_cnt <= 1'b1;
                        end
                    end
                end
                ST_SAMPLE: begin
                    if (tick) begin
                        raw[bit_idx] <= ~sync[1];
                        if (bit_idx == 3'd7) begin
                            state <= ST_COMMIT;
                        end else begin
                            state   <= ST_PULSE;
                            O_PULSE <= 1'b1;
                        end
                    end
                end
                ST_PULSE: begin
                    if (tick) begin
                        state   <= ST_SAMPLE;
                        O_PULSE <= 1'b0;
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                ST_COMMIT: begin
                    // Only a frame that matches its predecessor reaches the outputs.
                    if (raw == prev_raw) O_BUTTONS <= raw;
                    prev_raw <= raw;
                    state    <= ST_IDLE;
                    O_BUSY   <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    O_LATCH <= 1'b0;
                    O_PULSE <= 1'b0;
                    O_BUSY  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        dir_n = {~O_BUTTONS[BTN_DOWN], ~O_BUTTONS[BTN_UP],
                 ~O_BUTTONS[BTN_LEFT], ~O_BUTTONS[BTN_RIGHT]};
        btn_n = {~O_BUTTONS[BTN_START], ~O_BUTTONS[BTN_SELECT],
                 ~O_BUTTONS[BTN_B], ~O_BUTTONS[BTN_A]};
        O_JOYP_LO = 4'hF;
        if (!I_SEL_DIR_N) O_JOYP_LO = O_JOYP_LO & dir_n;
        if (!I_SEL_BTN_N) O_JOYP_LO = O_JOYP_LO & btn_n;
    end

    always_ff @(posedge I_CLK_33MHZ or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            joyp_prev <= 4'hF;
            O_INT     <= 1'b0;
        end else begin
            joyp_prev <= O_JOYP_LO;
            O_INT     <= |(joyp_prev & ~O_JOYP_LO);
        end
    end

endmodule

// File: tb/tb_joypad_scheduler.sv
// Directed bench for joypad_scheduler with a shift-register controller model.
module tb_joypad_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       poll_en = 1'b0;
    logic       sel_dir_n = 1'b1;
    logic       sel_btn_n = 1'b1;
    logic [7:0] pattern = 8'h00;
    logic [2:0] model_idx = 3'd0;
    logic       data;

    logic       o_latch, o_pulse, o_int, o_busy;
    logic [7:0] o_buttons;
    logic [3:0] o_joyp_lo;

    int checks = 0;
    int failures = 0;

    int cur_latch_len = 0, cur_pulses = 0, cur_pulse_len = 0, cur_pulse_bad = 0, cur_busy_len = 0;
    int last_latch_len = 0, last_pulses = 0, last_pulse_bad = 0, last_busy_len = 0;
    int frames_done = 0, int_clks = 0, bit4_clks = 0, latch_rises = 0;
    logic prev_latch = 1'b0, prev_pulse = 1'b0, prev_busy = 1'b0;

    assign data = ~pattern[model_idx];

    always #5 clk = ~clk;

    joypad_scheduler #(.TICK_CYCLES(4), .POLL_TICKS(20)) dut (
        .I_CLK_33MHZ(clk),
        .I_RESET_N  (rst_n),
        .I_DATA     (data),
        .I_POLL_EN  (poll_en),
        .I_SEL_DIR_N(sel_dir_n),
        .I_SEL_BTN_N(sel_btn_n),
        .O_LATCH    (o_latch),
        .O_PULSE    (o_pulse),
        .O_BUTTONS  (o_buttons),
        .O_JOYP_LO  (o_joyp_lo),
        .O_INT      (o_int),
        .O_BUSY     (o_busy)
    );

    // Controller model and frame monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (o_latch && !prev_latch) begin
            cur_latch_len <= 1;
            cur_pulses    <= 0;
            cur_pulse_bad <= 0;
            latch_rises   <= latch_rises + 1;
            model_idx     <= 3'd0;
        end else if (o_latch) begin
            cur_latch_len <= cur_latch_len + 1;
        end
        if (o_pulse && !prev_pulse) begin
            cur_pulses    <= cur_pulses + 1;
            cur_pulse_len <= 1;
            if (model_idx != 3'd7) model_idx <= model_idx + 3'd1;
        end else if (o_pulse) begin
            cur_pulse_len <= cur_pulse_len + 1;
        end
        if (!o_pulse && prev_pulse && cur_pulse_len != 4) cur_pulse_bad <= cur_pulse_bad + 1;
        if (o_busy && !prev_busy) cur_busy_len <= 1;
        else if (o_busy) cur_busy_len <= cur_busy_len + 1;
        if (!o_busy && prev_busy) begin
            frames_done    <= frames_done + 1;
            last_latch_len <= cur_latch_len;
            last_pulses    <= cur_pulses;
            last_pulse_bad <= cur_pulse_bad;
            last_busy_len  <= cur_busy_len;
        end
        if (o_int) int_clks <= int_clks + 1;
        if (o_buttons[4]) bit4_clks <= bit4_clks + 1;
        prev_latch <= o_latch;
        prev_pulse <= o_pulse;
        prev_busy  <= o_busy;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_frames(input int n, input string tag);
        int start;
        int cyc;
        start = frames_done;
        cyc = 0;
        while (frames_done < start + n && cyc < 200 * n) begin
            step(1);
            cyc++;
        end
        checks++;
        if (frames_done < start + n) begin
            failures++;
            $display("FAIL %s_timeout: frames=%0d required=%0d", tag, frames_done - start, n);
        end
        step(3);
    endtask

    task automatic test_reset();
        sel_dir_n = 1'b0;
        sel_btn_n = 1'b0;
        step(3);
        checks++; if (o_latch !== 1'b0) begin failures++; $display("FAIL reset_latch: got=%b want=0", o_latch); end
        checks++; if (o_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse: got=%b want=0", o_pulse); end
        checks++; if (o_buttons !== 8'h00) begin failures++; $display("FAIL reset_buttons: got=%h want=00", o_buttons); end
        checks++; if (o_int !== 1'b0) begin failures++; $display("FAIL reset_int: got=%b want=0", o_int); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got=%b want=0", o_busy); end
        checks++; if (o_joyp_lo !== 4'hF) begin failures++; $display("FAIL reset_joyp: got=%h want=F", o_joyp_lo); end
        sel_dir_n = 1'b1;
        sel_btn_n = 1'b1;
        step(1);
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_idle_frame();
        poll_en = 1'b1;
        pattern = 8'h00;
        wait_frames(1, "idle_frame");
        checks++; if (last_latch_len !== 8) begin failures++; $display("FAIL idle_latch_len: got=%0d want=8", last_latch_len); end
        checks++; if (last_pulses !== 7) begin failures++; $display("FAIL idle_pulses: got=%0d want=7", last_pulses); end
        checks++; if (last_pulse_bad !== 0) begin failures++; $display("FAIL idle_pulse_width: bad=%0d want=0", last_pulse_bad); end
        checks++; if (last_busy_len !== 69) begin failures++; $display("FAIL idle_frame_len: got=%0d want=69", last_busy_len); end
        checks++; if (o_buttons !== 8'h00) begin failures++; $display("FAIL idle_buttons: got=%h want=00", o_buttons); end
    endtask

    task automatic test_press();
        int i0;
        sel_dir_n = 1'b0;
        pattern = 8'h81;
        wait_frames(1, "press_f1");
        checks++; if (o_buttons !== 8'h00) begin failures++; $display("FAIL press_frame1: got=%h want=00", o_buttons); end
        i0 = int_clks;
        wait_frames(1, "press_f2");
        checks++; if (o_buttons !== 8'h81) begin failures++; $display("FAIL press_frame2: got=%h want=81", o_buttons); end
        checks++; if (o_joyp_lo !== 4'hE) begin failures++; $display("FAIL press_joyp_dir: got=%h want=E", o_joyp_lo); end
        checks++; if (int_clks - i0 !== 1) begin failures++; $display("FAIL press_int: cycles=%0d want=1", int_clks - i0); end
        i0 = int_clks;
        sel_dir_n = 1'b1;
        step(3);
        checks++; if (o_joyp_lo !== 4'hF) begin failures++; $display("FAIL press_joyp_none: got=%h want=F", o_joyp_lo); end
        sel_btn_n = 1'b0;
        step(3);
        checks++; if (o_joyp_lo !== 4'hE) begin failures++; $display("FAIL press_joyp_btn: got=%h want=E", o_joyp_lo); end
        checks++; if (int_clks - i0 !== 1) begin failures++; $display("FAIL press_sel_int: cycles=%0d want=1", int_clks - i0); end
        sel_btn_n = 1'b1;
        step(2);
        sel_dir_n = 1'b0;
        step(3);
    endtask

    task automatic test_glitch();
        int i0;
        int b0;
        i0 = int_clks;
        b0 = bit4_clks;
        pattern = 8'h91;
        wait_frames(1, "glitch_f1");
        pattern = 8'h81;
        wait_frames(2, "glitch_f2");
        checks++; if (bit4_clks - b0 !== 0) begin failures++; $display("FAIL glitch_up_seen: cycles=%0d want=0", bit4_clks - b0); end
        checks++; if (int_clks - i0 !== 0) begin failures++; $display("FAIL glitch_int: cycles=%0d want=0", int_clks - i0); end
        checks++; if (o_buttons !== 8'h81) begin failures++; $display("FAIL glitch_buttons: got=%h want=81", o_buttons); end
    endtask

    task automatic test_both_sel();
        pattern = 8'h21;
        wait_frames(2, "both_sel");
        checks++; if (o_buttons !== 8'h21) begin failures++; $display("FAIL both_buttons: got=%h want=21", o_buttons); end
        sel_dir_n = 1'b0;
        sel_btn_n = 1'b0;
        step(2);
        checks++; if (o_joyp_lo !== 4'h6) begin failures++; $display("FAIL both_joyp: got=%h want=6", o_joyp_lo); end
        sel_dir_n = 1'b1;
        sel_btn_n = 1'b1;
        step(2);
        checks++; if (o_joyp_lo !== 4'hF) begin failures++; $display("FAIL neither_joyp: got=%h want=F", o_joyp_lo); end
    endtask

    task automatic test_reset_mid();
        int i0;
        int l0;
        int cyc;
        sel_dir_n = 1'b0;
        pattern = 8'h81;
        wait_frames(2, "rstmid_setup");
        checks++; if (o_joyp_lo !== 4'hE) begin failures++; $display("FAIL rstmid_pre_joyp: got=%h want=E", o_joyp_lo); end
        cyc = 0;
        while (!(o_pulse && cur_pulses == 4) && cyc < 200) begin
            step(1);
            cyc++;
        end
        checks++;
        if (!(o_pulse && cur_pulses == 4)) begin
            failures++;
            $display("FAIL rstmid_pulse3_timeout: pulses=%0d want=4", cur_pulses);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (o_pulse !== 1'b0) begin failures++; $display("FAIL rstmid_pulse: got=%b want=0", o_pulse); end
        checks++; if (o_latch !== 1'b0) begin failures++; $display("FAIL rstmid_latch: got=%b want=0", o_latch); end
        checks++; if (o_buttons !== 8'h00) begin failures++; $display("FAIL rstmid_buttons: got=%h want=00", o_buttons); end
        step(3);
        rst_n = 1'b1;
        i0 = int_clks;
        l0 = latch_rises;
        step(70);
        checks++; if (int_clks - i0 !== 0) begin failures++; $display("FAIL rstmid_release_int: cycles=%0d want=0", int_clks - i0); end
        checks++; if (latch_rises - l0 !== 0) begin failures++; $display("FAIL rstmid_early_frame: frames=%0d want=0", latch_rises - l0); end
        wait_frames(1, "rstmid_next");
        checks++; if (last_latch_len !== 8) begin failures++; $display("FAIL rstmid_next_latch: got=%0d want=8", last_latch_len); end
        checks++; if (last_pulses !== 7) begin failures++; $display("FAIL rstmid_next_pulses: got=%0d want=7", last_pulses); end
    endtask

    task automatic test_poll_dis();
        int l0;
        int cyc;
        poll_en = 1'b0;
        l0 = latch_rises;
        step(240);
        checks++; if (latch_rises - l0 !== 0) begin failures++; $display("FAIL polldis_latch: frames=%0d want=0", latch_rises - l0); end
        poll_en = 1'b1;
        cyc = 0;
        while (!o_busy && cyc < 200) begin
            step(1);
            cyc++;
        end
        checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL polldis_start_timeout: busy=%b want=1", o_busy); end
        step(8);
        poll_en = 1'b0;
        wait_frames(1, "polldis_mid");
        checks++; if (last_pulses !== 7) begin failures++; $display("FAIL polldis_mid_pulses: got=%0d want=7", last_pulses); end
        checks++; if (last_latch_len !== 8) begin failures++; $display("FAIL polldis_mid_latch: got=%0d want=8", last_latch_len); end
        l0 = latch_rises;
        step(200);
        checks++; if (latch_rises - l0 !== 0) begin failures++; $display("FAIL polldis_after: frames=%0d want=0", latch_rises - l0); end
    endtask

    initial begin
        test_reset();
        test_idle_frame();
        test_press();
        test_glitch();
        test_both_sel();
        test_reset_mid();
        test_poll_dis();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/joypad_scheduler.md
JOYPAD_SCHEDULER -- requirements
Module: joypad_scheduler

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 198; clocks per protocol tick (6 us at 33 MHz).
REQ-002 SHALL have parameter POLL_TICKS, default 2750; ticks between frame starts (~60 Hz); legal values >= 18.
REQ-003 I_CLK_33MHZ  in  1  sole clock; all state on rising edge.
REQ-004 I_RESET_N  in  1  asynchronous, active-low reset.
REQ-005 I_DATA  in  1  controller serial data, active-low (0 = pressed), asynchronous to clock.
REQ-006 I_POLL_EN  in  1  1 = frames may start; sampled only at frame start.
REQ-007 I_SEL_DIR_N  in  1  P14 select, active-low, selects direction group.
REQ-008 I_SEL_BTN_N  in  1  P15 select, active-low, selects button group.
REQ-009 O_LATCH  out  1  controller latch strobe.
REQ-010 O_PULSE  out  1  controller shift clock.
REQ-011 O_BUTTONS  out  8  debounced state, 1 = pressed; bit order A,B,Select,Start,Up,Down,Left,Right = bits 0..7.
REQ-012 O_JOYP_LO  out  4  P10..P13, active-low, combinational from O_BUTTONS and selects.
REQ-013 O_INT  out  1  one-cycle joypad interrupt pulse.
REQ-014 O_BUSY  out  1  1 while state is not IDLE.

Function
REQ-015 I_DATA SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-016 Tick generator SHALL assert a one-cycle tick every TICK_CYCLES clocks, free-running from reset.
REQ-017 Poll counter SHALL count ticks 0..POLL_TICKS-1 and wrap; at wrap, if state is IDLE and I_POLL_EN=1, state SHALL go to LATCH; otherwise that start is dropped.
REQ-018 States: IDLE, LATCH, SAMPLE, PULSE, COMMIT.
REQ-019 LATCH: O_LATCH=1 for exactly 2 ticks; bit_idx cleared to 0; then SAMPLE.
REQ-020 SAMPLE: O_LATCH=0, O_PULSE=0 for 1 tick; on the tick ending SAMPLE, raw[bit_idx] = ~data_sync; bit_idx=7 -> COMMIT, else -> PULSE.
REQ-021 PULSE: O_PULSE=1 for 1 tick; bit_idx increments on exit; then SAMPLE. Exactly 7 pulses per frame; no pulse after bit 7.
REQ-022 Frame length SHALL be 17 ticks from LATCH entry to COMMIT entry.
REQ-023 COMMIT (1 clock): if raw equals previous frame's raw, O_BUTTONS <= raw; previous raw <= raw; -> IDLE. Thus a change appears after two consecutive identical frames.
REQ-024 I_POLL_EN deasserted mid-frame SHALL NOT abort the frame.
REQ-025 O_JOYP_LO: DIR selected -> {~Down,~Up,~Left,~Right} at bits 3..0; BTN selected -> {~Start,~Select,~B,~A}; both selected -> bitwise AND of both; neither -> 4'hF.
REQ-026 O_INT SHALL pulse 1 cycle the clock after any O_JOYP_LO bit falls 1->0 (registered previous value), whether caused by O_BUTTONS update or select change.

Reset
REQ-027 Reset SHALL asynchronously force: state IDLE, tick and poll counters 0, bit_idx 0, raw and previous raw 0, O_LATCH 0, O_PULSE 0, O_BUTTONS 0, O_INT 0, O_BUSY 0, synchronizer flops 1 (released).
REQ-028 Reset asserted mid-frame SHALL drop O_LATCH/O_PULSE immediately; first frame after release starts at first poll wrap.
REQ-029 O_JOYP_LO SHALL equal 4'hF during reset; previous-value register resets to 4'hF so no O_INT on release.

Structure
REQ-030 Shared package joypad_pkg SHALL hold the state enumeration, button bit index constants, and TICK_CYCLES/POLL_TICKS defaults.
REQ-031 Sub-module joypad_tick_gen SHALL implement the tick prescaler and poll counter, outputting tick and poll_start.

Verification (bench uses TICK_CYCLES=4, POLL_TICKS=20)
REQ-032 I_POLL_EN=1, I_DATA model all released -> O_LATCH high 8 clocks, then 7 O_PULSE highs of 4 clocks each; O_BUTTONS stays 8'h00.
REQ-033 Model holds A and Right (bits 0,7) -> O_BUTTONS=8'h00 after frame 1, 8'h81 after frame 2; I_SEL_DIR_N=0 gives O_JOYP_LO=4'hE with O_INT pulse 1 cycle.
REQ-034 Glitch: Up pressed in one frame only -> O_BUTTONS never shows bit 4; O_INT stays 0.
REQ-035 Both selects low, A and Down pressed -> O_JOYP_LO=4'h6; neither low -> 4'hF.
REQ-036 I_RESET_N pulsed low during PULSE of bit 3 -> O_PULSE, O_LATCH, O_BUTTONS 0 same cycle; no O_INT on release; next frame completes normally.
REQ-037 I_POLL_EN=0 -> no O_LATCH for 3 poll periods; dropped mid-frame -> current frame finishes with 7 pulses.
